// File: rtl/gth_link_pkg.sv
// Shared types and constants for the GTH link sequencer: state encoding and datapath words.
package gth_link_pkg;

    typedef enum logic [2:0] {
        RESET_HOLD   = 3'd0,
        WAIT_PWRGOOD = 3'd1,
        WAIT_PMA     = 3'd2,
        WAIT_DONE    = 3'd3,
        TRAIN        = 3'd4,
        LINK_UP      = 3'd5,
        FAULT        = 3'd6
    } link_state_t;

    localparam logic [9:0] TRAIN_WORD_A = 10'h2AA;
    localparam logic [9:0] TRAIN_WORD_B = 10'h155;
    localparam logic [9:0] IDLE_WORD    = 10'h000;

    // Status vector packing: {tx_done, prgdiv[2:0], pma[2:0], pwrgood[2:0]}
    localparam int STATUS_W = 10;

    function automatic logic all_lanes(input logic [2:0] lanes);
        return &lanes;
    endfunction

endpackage

// File: rtl/gth_link_sequencer_sync.sv
// Parameterised-width two-flop synchronizer for GT status bits; used when GTH_LINK_SEQ_SYNC_EN is defined.
module gth_status_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] synced
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta   <= '0;
            synced <= '0;
        end else begin
            meta   <= raw;
            synced <= meta;
        end
    end

endmodule

// File: rtl/gth_link_sequencer.sv
// Bring-up and supervision FSM for the 3-lane GTH pixel serializer, with training and retry/fault handling.
// Optional macro GTH_LINK_SEQ_SYNC_EN adds a 2-flop synchronizer on every GT status input.
module gth_link_sequencer
    import gth_link_pkg::*;
#(
    parameter int RESET_HOLD_CYCLES = 64,
    parameter int STAGE_TIMEOUT     = 1048576,
    parameter int TRAIN_CYCLES      = 1024,
    parameter int MAX_RETRIES       = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       restart,
    input  logic [2:0] gtpowergood_in,
    input  logic [2:0] txpmaresetdone_in,
    input  logic [2:0] txprgdivresetdone_in,
    input  logic       gtwiz_reset_tx_done_in,
    input  logic [9:0] r_in,
    input  logic [9:0] g_in,
    input  logic [9:0] b_in,
    output logic       gt_reset_out,
    output logic [9:0] r_out,
    output logic [9:0] g_out,
    output logic [9:0] b_out,
    output logic       link_up,
    output logic       fault,
    output logic [3:0] retry_cnt,
    output logic [2:0] state_out
);

    logic [STATUS_W-1:0] status_raw;
    logic [STATUS_W-1:0] status;

    assign status_raw = {gtwiz_reset_tx_done_in, txprgdivresetdone_in,
                         txpmaresetdone_in, gtpowergood_in};

`ifdef GTH_LINK_SEQ_SYNC_EN
    gth_status_sync #(.WIDTH(STATUS_W)) u_status_sync (
        .clk    (clk),
        .reset  (reset),
        .raw    (status_raw),
        .synced (status)
    );
`else
    assign status = status_raw;
`endif

    logic pg_ok;
    logic pma_ok;
    logic tx_done;

    assign pg_ok   = all_lanes(status[2:0]);
    assign pma_ok  = all_lanes(status[5:3]) && all_lanes(status[8:6]);
    assign tx_done = status[9];

    link_state_t state;
    link_state_t next_state;
    logic [31:0] timer;
    logic [3:0]  next_retry;
    logic        fail;
    logic        alt;
    logic        stage_timeout;

    assign stage_timeout = (timer == 32'(STAGE_TIMEOUT - 1));

    always_comb begin
        next_state = state;
        next_retry = retry_cnt;
        fail       = 1'b0;

        case (state)
            RESET_HOLD: begin
                if (timer == 32'(RESET_HOLD_CYCLES - 1)) next_state = WAIT_PWRGOOD;
            end
            WAIT_PWRGOOD: begin
                if (pg_ok)              next_state = WAIT_PMA;
                else if (stage_timeout) fail = 1'b1;
            end
            WAIT_PMA: begin
                if (!pg_ok)             fail = 1'b1;
                else if (pma_ok)        next_state = WAIT_DONE;
                else if (stage_timeout) fail = 1'b1;
            end
            WAIT_DONE: begin
                if (!pg_ok)             fail = 1'b1;
                else if (tx_done)       next_state = TRAIN;
                else if (stage_timeout) fail = 1'b1;
            end
            TRAIN: begin
                if (!pg_ok) fail = 1'b1;
                else if (timer == 32'(TRAIN_CYCLES - 1)) next_state = LINK_UP;
            end
            LINK_UP: begin
                if (!pg_ok || !tx_done) fail = 1'b1;
            end
            FAULT: begin
                next_state = FAULT;
            end
            default: begin
                next_state = RESET_HOLD;
            end
        endcase

        if (fail) begin
            if (retry_cnt == 4'(MAX_RETRIES)) begin
                next_state = FAULT;
            end else begin
                next_retry = retry_cnt + 4'd1;
                next_state = RESET_HOLD;
            end
        end

        if (next_state == LINK_UP && state != LINK_UP) next_retry = 4'd0;

        // restart overrides every other transition, including a same-cycle failure
        if (restart) begin
            next_state = RESET_HOLD;
            next_retry = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RESET_HOLD;
            timer     <= 32'd0;
            retry_cnt <= 4'd0;
            alt       <= 1'b0;
            r_out     <= IDLE_WORD;
            g_out     <= IDLE_WORD;
            b_out     <= IDLE_WORD;
        end else begin
            state     <= next_state;
            retry_cnt <= next_retry;

            if (restart || next_state != state) timer <= 32'd0;
            else                                timer <= timer + 32'd1;

            if (next_state == TRAIN && state != TRAIN) alt <= 1'b0;
            else if (state == TRAIN)                  alt <= ~alt;

            case (state)
                LINK_UP: begin
                    r_out <= r_in;
                    g_out <= g_in;
                    b_out <= b_in;
                end
                TRAIN: begin
                    r_out <= alt ? TRAIN_WORD_B : TRAIN_WORD_A;
                    g_out <= alt ? TRAIN_WORD_B : TRAIN_WORD_A;
                    b_out <= alt ? TRAIN_WORD_B : TRAIN_WORD_A;
                end
                default: begin
                    r_out <= IDLE_WORD;
                    g_out <= IDLE_WORD;
                    b_out <= IDLE_WORD;
                end
            endcase
        end
    end

    assign gt_reset_out = (state == RESET_HOLD);
    assign link_up      = (state == LINK_UP);
    assign fault        = (state == FAULT);
    assign state_out    = state;

endmodule

// File: tb/tb_gth_link_sequencer.sv
// Directed self-checking bench for gth_link_sequencer (HOLD=4, TIMEOUT=32, TRAIN=8, MAX_RETRIES=2).
module tb_gth_link_sequencer;
    import gth_link_pkg::*;

`ifdef GTH_LINK_SEQ_SYNC_EN
    localparam int SL = 2;
`else
    localparam int SL = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       restart;
    logic [2:0] gtpowergood_in;
    logic [2:0] txpmaresetdone_in;
    logic [2:0] txprgdivresetdone_in;
    logic       gtwiz_reset_tx_done_in;
    logic [9:0] r_in, g_in, b_in;
    logic       gt_reset_out;
    logic [9:0] r_out, g_out, b_out;
    logic       link_up;
    logic       fault;
    logic [3:0] retry_cnt;
    logic [2:0] state_out;

    int checks = 0;
    int errors = 0;
    logic [29:0] exp_q[$];

    gth_link_sequencer #(
        .RESET_HOLD_CYCLES (4),
        .STAGE_TIMEOUT     (32),
        .TRAIN_CYCLES      (8),
        .MAX_RETRIES       (2)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .restart                (restart),
        .gtpowergood_in         (gtpowergood_in),
        .txpmaresetdone_in      (txpmaresetdone_in),
        .txprgdivresetdone_in   (txprgdivresetdone_in),
        .gtwiz_reset_tx_done_in (gtwiz_reset_tx_done_in),
        .r_in                   (r_in),
        .g_in                   (g_in),
        .b_in                   (b_in),
        .gt_reset_out           (gt_reset_out),
        .r_out                  (r_out),
        .g_out                  (g_out),
        .b_out                  (b_out),
        .link_up                (link_up),
        .fault                  (fault),
        .retry_cnt              (retry_cnt),
        .state_out              (state_out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] target, input int budget, output int n);
        n = 0;
        while (state_out !== target && n < budget) begin
            step();
            n++;
        end
    endtask

    task automatic drive_video();
        r_in = 10'($urandom_range(0, 1023));
        g_in = 10'($urandom_range(0, 1023));
        b_in = 10'($urandom_range(0, 1023));
    endtask

    task automatic pop_words(input string tag);
        logic [29:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, " queue empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk(tag, {r_out, g_out, b_out}, e);
        end
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        step();
        restart = 1'b0;
    endtask

    initial begin
        int n;
        logic [9:0] w;

        reset = 1'b1;
        restart = 1'b0;
        gtpowergood_in = 3'b000;
        txpmaresetdone_in = 3'b000;
        txprgdivresetdone_in = 3'b000;
        gtwiz_reset_tx_done_in = 1'b0;
        r_in = '0; g_in = '0; b_in = '0;
        repeat (3) step();

        chk("reset state", state_out, 3'd0);
        chk("reset gt_reset", gt_reset_out, 1'b1);
        chk("reset link_up", link_up, 1'b0);
        chk("reset fault", fault, 1'b0);
        chk("reset retry", retry_cnt, 4'd0);
        chk("reset rgb", {r_out, g_out, b_out}, 30'd0);

        // normal bring-up
        reset = 1'b0;
        n = 0;
        while (gt_reset_out === 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("hold cycles", n, 4);
        chk("enter wait_pwrgood", state_out, 3'd1);
        gtpowergood_in = 3'b111;
        wait_state(3'd2, 20, n);
        chk("pwrgood latency", n, 1 + SL);
        txpmaresetdone_in = 3'b111;
        txprgdivresetdone_in = 3'b111;
        wait_state(3'd3, 20, n);
        chk("pma latency", n, 1 + SL);
        gtwiz_reset_tx_done_in = 1'b1;
        wait_state(3'd4, 20, n);
        chk("done latency", n, 1 + SL);

        for (int i = 0; i < 8; i++) begin
            w = (i % 2 == 0) ? 10'h2AA : 10'h155;
            exp_q.push_back({w, w, w});
        end
        for (int i = 0; i < 8; i++) begin
            drive_video();
            step();
            pop_words("train word");
        end
        chk("link state", state_out, 3'd5);
        chk("link_up high", link_up, 1'b1);
        chk("link retry", retry_cnt, 4'd0);
        chk("link gt_reset", gt_reset_out, 1'b0);
        for (int i = 0; i < 6; i++) begin
            drive_video();
            exp_q.push_back({r_in, g_in, b_in});
            step();
            pop_words("live video");
        end

        // link drop on lane 1 for one cycle
        gtpowergood_in = 3'b101;
        step();
        gtpowergood_in = 3'b111;
        wait_state(3'd0, 8, n);
        chk("drop latency", n, SL);
        chk("drop state", state_out, 3'd0);
        chk("drop retry", retry_cnt, 4'd1);
        step();
        chk("drop rgb idle", {r_out, g_out, b_out}, 30'd0);
        chk("drop gt_reset", gt_reset_out, 1'b1);
        wait_state(3'd5, 200, n);
        chk("relink state", state_out, 3'd5);
        chk("relink retry", retry_cnt, 4'd0);

        // restart from LINK_UP, then restart during TRAIN
        pulse_restart();
        chk("restart link state", state_out, 3'd0);
        wait_state(3'd4, 200, n);
        chk("reach train", state_out, 3'd4);
        repeat (3) step();
        pulse_restart();
        chk("restart train state", state_out, 3'd0);
        chk("restart train retry", retry_cnt, 4'd0);
        chk("restart train gt_reset", gt_reset_out, 1'b1);
        step();
        chk("restart train rgb", {r_out, g_out, b_out}, 30'd0);

        // power good never asserts: three attempts then FAULT
        gtpowergood_in = 3'b000;
        txpmaresetdone_in = 3'b000;
        txprgdivresetdone_in = 3'b000;
        gtwiz_reset_tx_done_in = 1'b0;
        pulse_restart();
        for (int a = 0; a < 3; a++) begin
            wait_state(3'd1, 10, n);
            chk("attempt hold", n, 4);
            wait_state((a < 2) ? 3'd0 : 3'd6, 40, n);
            chk("attempt wait", n, 32);
            chk("attempt retry", retry_cnt, (a < 2) ? a + 1 : 2);
        end
        chk("fault state", state_out, 3'd6);
        chk("fault high", fault, 1'b1);
        chk("fault gt_reset", gt_reset_out, 1'b0);
        step();
        chk("fault rgb", {r_out, g_out, b_out}, 30'd0);
        gtpowergood_in = 3'b111;
        repeat (5) step();
        chk("fault sticky", state_out, 3'd6);

        // restart from FAULT
        gtpowergood_in = 3'b000;
        pulse_restart();
        chk("restart fault state", state_out, 3'd0);
        chk("restart fault retry", retry_cnt, 4'd0);
        chk("restart fault gt_reset", gt_reset_out, 1'b1);

        // condition true on the timeout cycle advances without retry
        wait_state(3'd1, 10, n);
        chk("boundary hold", n, 4);
        repeat (31 - SL) step();
        gtpowergood_in = 3'b111;
        repeat (SL) step();
        chk("boundary no early advance", state_out, 3'd1);
        step();
        chk("boundary advance", state_out, 3'd2);
        chk("boundary retry", retry_cnt, 4'd0);

        // restart concurrent with WAIT_PMA timeout wins
        repeat (31) step();
        chk("pre-timeout state", state_out, 3'd2);
        pulse_restart();
        chk("restart vs timeout state", state_out, 3'd0);
        chk("restart vs timeout retry", retry_cnt, 4'd0);
        wait_state(3'd1, 10, n);
        chk("restart timer cleared", n, 4);

        // reset mid-operation from LINK_UP
        txpmaresetdone_in = 3'b111;
        txprgdivresetdone_in = 3'b111;
        gtwiz_reset_tx_done_in = 1'b1;
        wait_state(3'd5, 100, n);
        chk("final link", state_out, 3'd5);
        drive_video();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midreset state", state_out, 3'd0);
        chk("midreset link_up", link_up, 1'b0);
        chk("midreset rgb", {r_out, g_out, b_out}, 30'd0);
        chk("midreset gt_reset", gt_reset_out, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gth_link_sequencer.md
Name: gth_link_sequencer

Overview:
- Bring-up and supervision controller for the 3-lane GTH pixel serializer.
- Holds the GT wizard in reset, then checks power-good, PMA/PRGDIV reset-done and TX reset-done in order, each stage with a timeout.
- Sends a fixed training pattern, then switches the RGB datapath to live video.
- Retries a failed bring-up a bounded number of times, then latches a fault. Sits between the video source and the serializer's r/g/b/reset inputs.

Parameters:
- RESET_HOLD_CYCLES, 64: cycles gt_reset_out stays high per attempt (>=1).
- STAGE_TIMEOUT, 1048576: max cycles spent in any WAIT_* state before a retry.
- TRAIN_CYCLES, 1024: cycles of training pattern before LINK_UP (>=1).
- MAX_RETRIES, 3: retries allowed after the first attempt before FAULT.

Ports:
- clk  in  1  pixel clock, 148.5 MHz
- reset  in  1  synchronous, active-high
- restart  in  1  single-cycle pulse; forces a fresh bring-up and clears retry_cnt
- gtpowergood_in  in  3  per-lane GT power good
- txpmaresetdone_in  in  3  per-lane TX PMA reset done
- txprgdivresetdone_in  in  3  per-lane TX PRGDIV reset done
- gtwiz_reset_tx_done_in  in  1  wizard TX reset done
- r_in, g_in, b_in  in  10 each  live video words
- gt_reset_out  out  1  drives serializer reset
- r_out, g_out, b_out  out  10 each  words to serializer
- link_up  out  1  high in LINK_UP
- fault  out  1  high in FAULT
- retry_cnt  out  4  retries consumed in the current bring-up
- state_out  out  3  current state encoding

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- State encoding: RESET_HOLD=0, WAIT_PWRGOOD=1, WAIT_PMA=2, WAIT_DONE=3, TRAIN=4, LINK_UP=5, FAULT=6.
- Reset values: state RESET_HOLD, timer 0, retry_cnt 0, r/g/b_out 0, link_up 0, fault 0, gt_reset_out 1.
- Decoded outputs: gt_reset_out, link_up, fault and state_out decode directly from the state register, with no extra latency.
- Timer: cleared on every state change; increments every cycle otherwise.
- RESET_HOLD: leaves after RESET_HOLD_CYCLES cycles (timer==RESET_HOLD_CYCLES-1) to WAIT_PWRGOOD.
- WAIT_PWRGOOD: gtpowergood_in==3'b111 -> WAIT_PMA.
- WAIT_PMA: txpmaresetdone_in and txprgdivresetdone_in both 3'b111 -> WAIT_DONE.
- WAIT_DONE: gtwiz_reset_tx_done_in -> TRAIN.
- WAIT_* timeout: timer reaching STAGE_TIMEOUT-1 without its condition is a failure.
- TRAIN: leaves after TRAIN_CYCLES cycles -> LINK_UP. retry_cnt is cleared on entry to LINK_UP.
- Loss of status: in WAIT_PMA, WAIT_DONE, TRAIN or LINK_UP, gtpowergood_in!=3'b111 is a failure. In LINK_UP, gtwiz_reset_tx_done_in low is also a failure.
- Failure handling: if retry_cnt==MAX_RETRIES -> FAULT; else retry_cnt+1 -> RESET_HOLD. The condition is checked in the same cycle as the timeout; a stage whose condition is true on the timeout cycle advances.
- FAULT: sticky; only reset or restart leave it.
- restart: in any state -> RESET_HOLD next cycle with retry_cnt=0 and timer=0. Takes priority over all other transitions.
- Reset mid-operation: returns immediately to reset values. There is no partial state.
- Datapath: r/g/b_out are registered with 1-cycle latency from the state and the inputs.
  - Cycle after a LINK_UP cycle: carries r/g/b_in.
  - Cycle after a TRAIN cycle: carries the training word on all three channels, alternating 10'h2AA, 10'h155 and starting at 10'h2AA on the first TRAIN cycle. An alternation bit is cleared on TRAIN entry.
  - All other states: output 10'h000.
- retry_cnt saturates by construction, since MAX_RETRIES<=15.

Optional Feature:
- Macro: GTH_LINK_SEQ_SYNC_EN.
- Defined: every GT status input passes through a 2-flop synchronizer (reset to 0) before use, so status reactions occur 2 cycles later.
- Undefined: status inputs are used directly, and must already be in the clk domain.

Decomposition:
- Package gth_link_pkg holds the state enum (3-bit), TRAIN_WORD_A=10'h2AA, TRAIN_WORD_B=10'h155 and IDLE_WORD=10'h000.
- Sub-module gth_status_sync: parameterised-width 2-flop synchronizer, instantiated only under the macro.

Test Plan:
- Normal bring-up (HOLD=4, TIMEOUT=32, TRAIN=8): status rises during WAIT stages.
  - gt_reset_out high exactly 4 cycles after reset release.
  - State goes 0->1->2->3->4->5.
  - 8 training words 2AA,155,... then r_out==r_in one cycle later; link_up=1.
- Power good never asserts, MAX_RETRIES=2:
  - 3 attempts, each 4 reset cycles plus 32 wait cycles; retry_cnt 0->1->2.
  - Then FAULT, fault=1, gt_reset_out=0, outputs 0.
- Link drop: in LINK_UP, lower gtpowergood_in[1] for 1 cycle.
  - Next cycle state=RESET_HOLD, retry_cnt=1, r/g/b_out=0; re-bring-up reaches LINK_UP with retry_cnt=0.
- restart pulse in FAULT and in TRAIN:
  - Next cycle state=RESET_HOLD, retry_cnt=0, gt_reset_out=1.
- Boundary: condition true on the timeout cycle (timer==31) advances with no retry.
  - restart concurrent with a timeout wins.
- With GTH_LINK_SEQ_SYNC_EN: repeat the normal bring-up.
  - Each WAIT transition occurs exactly 2 cycles later than without the macro.
